// File: rtl/wb_host_port_pkg.sv
// Shared definitions for the Wishbone host port: FSM state type, status slot
// index, error read data, status register bit layout and a packing helper.
package wb_host_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0]  SLOT_STATUS = 2'd3;
  localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;
  localparam logic [7:0]  ERR_CNT_MAX = 8'hFF;

  // Status register layout: {14'b0, TO_SLOT[1:0], ERR_CNT[7:0], 6'b0, BAD, TO}
  localparam int unsigned STAT_TO_BIT   = 0;
  localparam int unsigned STAT_BAD_BIT  = 1;
  localparam int unsigned STAT_CNT_LSB  = 8;
  localparam int unsigned STAT_SLOT_LSB = 16;

  function automatic logic [31:0] pack_status(input logic       to,
                                              input logic       bad,
                                              input logic [7:0] cnt,
                                              input logic [1:0] slot);
    logic [31:0] word;
    word                              = '0;
    word[STAT_TO_BIT]                 = to;
    word[STAT_BAD_BIT]                = bad;
    word[STAT_CNT_LSB +: 8]           = cnt;
    word[STAT_SLOT_LSB +: 2]          = slot;
    return word;
  endfunction

endpackage

// File: rtl/wb_host_port_status.sv
// wb_status_reg: sticky error state of the host port.
//   clk, reset      : clock, synchronous active-high reset
//   to_event        : a device access timed out this cycle
//   to_slot         : slot of the timed-out access
//   bad_event       : an out-of-window or partial-select access this cycle
//   clear           : status write with bit 0 set; clears everything
//   status          : packed status register read value
//   err_irq         : registered OR of the sticky TO/BAD bits
module wb_status_reg
  import wb_host_port_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        to_event,
  input  logic [1:0]  to_slot,
  input  logic        bad_event,
  input  logic        clear,
  output logic [31:0] status,
  output logic        err_irq
);

  logic       to_q;
  logic       bad_q;
  logic [1:0] slot_q;
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      to_q   <= 1'b0;
      bad_q  <= 1'b0;
      slot_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (to_event) begin
        to_q   <= 1'b1;
        slot_q <= to_slot;
      end
      if (bad_event) begin
        bad_q <= 1'b1;
      end
      if ((to_event || bad_event) && (cnt_q != ERR_CNT_MAX)) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_irq <= 1'b0;
    end else begin
      err_irq <= to_q | bad_q;
    end
  end

  assign status = pack_status(to_q, bad_q, cnt_q, slot_q);

endmodule

// File: rtl/wb_host_port.sv
// wb_host_port: classic Wishbone front end for the user-project devices.
// Decodes a 4 KiB window into three device slots plus an internal status
// slot, pulses one device strobe per access, waits for the device ack or a
// timeout and returns a single acknowledge to the host.
//   clk, reset          : clock, synchronous active-high reset
//   wbs_*_i             : host Wishbone request
//   wbs_ack_o/wbs_dat_o : host acknowledge and registered read data
//   s_stb/s_we/s_adr/s_dat_o : per-slot strobe and latched request to devices
//   s_ack/s_dat_i       : per-slot device acknowledge and read data
//   err_irq             : registered OR of the sticky error bits
module wb_host_port
  import wb_host_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TO_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0]  s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_o,
  input  logic [2:0]  s_ack,
  input  logic [95:0] s_dat_i,
  output logic        err_irq
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  state_t          state;
  state_t          state_next;
  logic [1:0]      slot_q;
  logic [TO_W-1:0] cnt_q;

  logic            in_window;
  logic [1:0]      req_slot;
  logic            req_load;
  logic            dat_load;
  logic [31:0]     dat_next;
  logic            cnt_inc;
  logic            to_event;
  logic            bad_event;
  logic            stat_clear;
  logic [31:0]     status;
  logic            slot_ack;
  logic [31:0]     slot_rdata;

  assign in_window = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign req_slot  = wbs_adr_i[11:10];

  always_comb begin
    slot_ack   = 1'b0;
    slot_rdata = '0;
    case (slot_q)
      2'd0: begin slot_ack = s_ack[0]; slot_rdata = s_dat_i[31:0];  end
      2'd1: begin slot_ack = s_ack[1]; slot_rdata = s_dat_i[63:32]; end
      2'd2: begin slot_ack = s_ack[2]; slot_rdata = s_dat_i[95:64]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_load   = 1'b0;
    dat_load   = 1'b0;
    dat_next   = '0;
    cnt_inc    = 1'b0;
    to_event   = 1'b0;
    bad_event  = 1'b0;
    stat_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          state_next = ST_RESP;
          dat_load   = 1'b1;
          if (!in_window) begin
            bad_event = 1'b1;
          end else if (req_slot == SLOT_STATUS) begin
            dat_next   = status;
            stat_clear = wbs_we_i & wbs_dat_i[0];
          end else if (wbs_sel_i != 4'hF) begin
            bad_event = 1'b1;
          end else begin
            state_next = ST_REQ;
            dat_load   = 1'b0;
            req_load   = 1'b1;
          end
        end
      end
      ST_REQ: begin
        state_next = wbs_cyc_i ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        // Host abort outranks both the device ack and the timeout.
        if (!wbs_cyc_i) begin
          state_next = ST_IDLE;
        end else if (slot_ack) begin
          state_next = ST_RESP;
          dat_load   = 1'b1;
          dat_next   = slot_rdata;
        end else if (cnt_q == TO_LIMIT) begin
          state_next = ST_RESP;
          dat_load   = 1'b1;
          dat_next   = ERR_DATA;
          to_event   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q    <= '0;
      s_we      <= 1'b0;
      s_adr     <= '0;
      s_dat_o   <= '0;
      wbs_dat_o <= '0;
      cnt_q     <= '0;
    end else begin
      if (req_load) begin
        slot_q  <= req_slot;
        s_we    <= wbs_we_i;
        s_adr   <= wbs_adr_i - BASE_ADDR;
        s_dat_o <= wbs_dat_i;
      end
      if (dat_load) begin
        wbs_dat_o <= dat_next;
      end
      if (state == ST_REQ) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Strobe and ack are decoded from the registered state, so a synchronous
  // reset removes them on the very next cycle.
  always_comb begin
    s_stb = '0;
    if (state == ST_REQ) begin
      case (slot_q)
        2'd0:    s_stb = 3'b001;
        2'd1:    s_stb = 3'b010;
        2'd2:    s_stb = 3'b100;
        default: s_stb = '0;
      endcase
    end
  end

  assign wbs_ack_o = (state == ST_RESP);

  wb_status_reg u_status (
    .clk       (clk),
    .reset     (reset),
    .to_event  (to_event),
    .to_slot   (slot_q),
    .bad_event (bad_event),
    .clear     (stat_clear),
    .status    (status),
    .err_irq   (err_irq)
  );

endmodule

// File: tb/tb_wb_host_port.sv
// Self-checking bench for wb_host_port: directed cases plus randomized
// accesses compared against a transaction-level reference model.
module tb_wb_host_port;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [2:0]  s_stb;
  logic        s_we;
  logic [31:0] s_adr, s_dat_o;
  logic [2:0]  s_ack;
  logic [95:0] s_dat_i;
  logic        err_irq;

  wb_host_port #(.BASE_ADDR(32'h3000_0000), .TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
    .s_ack(s_ack), .s_dat_i(s_dat_i), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model of the sticky status
  bit m_to, m_bad;
  int m_cnt, m_slot;

  function automatic logic [31:0] m_status();
    return 32'((m_slot * 65536) + (m_cnt * 256) + (m_bad ? 2 : 0) + (m_to ? 1 : 0));
  endfunction

  task automatic m_error();
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic m_clear();
    m_to = 0; m_bad = 0; m_cnt = 0; m_slot = 0;
  endtask

  // One host access. d: device ack delay after entering WAIT (-1 = never).
  // ab: cycle (relative to the decode cycle) in which the host drops cyc, 0 = never.
  task automatic run_access(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                            input logic [31:0] dat, input logic [31:0] rdata,
                            input int d, input int ab);
    logic [31:0] w[3];
    int kind, slot, ack_cyc, exp_ack, first_ack, n_ack, stray, eff_ab;
    logic [31:0] exp_dat, ack_dat;
    bit chk_dat;
    slot = int'(adr[11:10]);
    for (int i = 0; i < 3; i++) w[i] = $urandom();
    if (slot < 3) w[slot] = rdata;
    if (adr[31:12] != 20'h30000) kind = 1;
    else if (slot == 3) kind = 0;
    else if (sel != 4'hF) kind = 1;
    else kind = 2;
    eff_ab  = (kind == 2) ? ab : 0;
    chk_dat = 1;
    exp_dat = '0;
    exp_ack = -1;
    if (kind == 0) begin
      exp_ack = 1; exp_dat = m_status(); chk_dat = !we;
      if (we && dat[0]) m_clear();
    end else if (kind == 1) begin
      exp_ack = 1; m_bad = 1; m_error();
    end else begin
      ack_cyc = (d >= 0 && d <= TMO) ? 2 + d : -1;
      if (eff_ab > 0 && (ack_cyc < 0 || eff_ab <= ack_cyc)) begin
        exp_ack = -1;
      end else if (ack_cyc >= 0) begin
        exp_ack = ack_cyc + 1; exp_dat = w[slot];
      end else begin
        exp_ack = TMO + 3; exp_dat = 32'hDEAD_BEEF;
        m_to = 1; m_slot = slot; m_error();
      end
    end

    @(negedge clk);
    s_dat_i   = {w[2], w[1], w[0]};
    s_ack     = '0;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
    first_ack = -1; n_ack = 0; stray = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (kind == 2) begin
          check_eq("s_stb", 32'(s_stb), 32'(1 << slot));
          check_eq("s_we", 32'(s_we), 32'(we));
          check_eq("s_adr", s_adr, adr - 32'h3000_0000);
          check_eq("s_dat_o", s_dat_o, dat);
        end else begin
          check_eq("no_stb", 32'(s_stb), 32'd0);
        end
      end else if (s_stb != 0) begin
        stray++;
      end
      if (wbs_ack_o) begin
        n_ack++;
        if (first_ack < 0) begin first_ack = k; ack_dat = wbs_dat_o; end
        wbs_cyc_i = 0; wbs_stb_i = 0;
      end
      s_ack = '0;
      if (kind == 2 && d >= 0 && k == 2 + d) s_ack = 3'(1 << slot);
      if (eff_ab > 0 && k == eff_ab) begin wbs_cyc_i = 0; wbs_stb_i = 0; end
      if (first_ack >= 0 && k >= first_ack + 3) break;
      if (exp_ack < 0 && eff_ab > 0 && k >= eff_ab + 4 && first_ack < 0) break;
    end
    s_ack = '0; wbs_cyc_i = 0; wbs_stb_i = 0;
    check_eq("ack_cycle", 32'(first_ack), 32'(exp_ack));
    check_eq("ack_count", 32'(n_ack), (exp_ack >= 0) ? 32'd1 : 32'd0);
    check_eq("stray_stb", 32'(stray), 32'd0);
    if (exp_ack >= 0 && first_ack >= 0 && chk_dat) check_eq("rdata", ack_dat, exp_dat);
    @(negedge clk);
    check_eq("err_irq", 32'(err_irq), 32'(m_to | m_bad));
  endtask

  task automatic status_read();
    run_access(32'h3000_0C00, 0, 4'hF, 0, 0, 0, 0);
  endtask

  task automatic reset_mid_access();
    int n_ack;
    @(negedge clk);
    s_dat_i   = {3{$urandom()}};
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3000_0010; wbs_dat_i = 32'h5A5A_0F0F;
    @(negedge clk);                     // REQ
    @(negedge clk);                     // WAIT
    reset = 1; s_ack = 3'b001;
    @(negedge clk);
    check_eq("rst_ack", 32'(wbs_ack_o), 32'd0);
    check_eq("rst_dat", wbs_dat_o, 32'd0);
    check_eq("rst_stb", 32'(s_stb), 32'd0);
    check_eq("rst_sreq", {s_we, s_adr[30:0]} | s_dat_o, 32'd0);
    check_eq("rst_irq", 32'(err_irq), 32'd0);
    m_clear();
    reset = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
    n_ack = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) s_ack = '0;
      if (wbs_ack_o) n_ack++;
    end
    check_eq("rst_no_ack", 32'(n_ack), 32'd0);
  endtask

  initial begin
    int d, ab, ackc;
    logic [31:0] adr;
    reset = 1; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0; s_ack = 0; s_dat_i = 0;
    m_clear();
    repeat (3) @(negedge clk);
    check_eq("reset_outs", {wbs_ack_o, s_stb, s_we, err_irq} | wbs_dat_o | s_adr | s_dat_o, 32'd0);
    reset = 0;

    run_access(32'h3000_0000, 0, 4'hF, 0, 32'h1234_5678, 0, 0);
    run_access(32'h3000_0404, 1, 4'hF, 32'hCAFE_0001, $urandom(), 3, 0);
    run_access(32'h3000_0800, 0, 4'hF, 0, $urandom(), -1, 0);
    status_read();
    run_access(32'h3100_0000, 0, 4'hF, 0, 0, 0, 0);
    run_access(32'h3000_0000, 1, 4'h3, 32'h1, 0, 0, 0);
    status_read();
    run_access(32'h3000_0C00, 1, 4'hF, 32'h1, 0, 0, 0);
    status_read();
    run_access(32'h3000_0408, 0, 4'hF, 0, $urandom(), 10, 5);   // abort in WAIT
    run_access(32'h3000_0408, 0, 4'hF, 0, $urandom(), 2, 0);
    run_access(32'h3000_0004, 0, 4'hF, 0, $urandom(), 4, 6);    // abort vs ack same cycle
    run_access(32'h3000_0004, 0, 4'hF, 0, $urandom(), 0, 1);    // abort in REQ
    run_access(32'h3000_0804, 0, 4'hF, 0, $urandom(), TMO, 0);  // ack on the last cycle
    run_access(32'h3000_0404, 0, 4'hF, 0, $urandom(), TMO + 1, 0);
    status_read();

    for (int n = 0; n < 200; n++) begin
      adr = ($urandom_range(0, 7) == 0) ? $urandom() : (32'h3000_0000 | 32'($urandom_range(0, 4095)));
      d = ($urandom_range(0, 39) == 0) ? -1 : $urandom_range(0, 12);
      ackc = (d < 0) ? 20 : 2 + d;
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, ackc) : 0;
      run_access(adr, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF,
                 $urandom(), $urandom(), d, ab);
    end
    status_read();

    run_access(32'h3000_0C00, 1, 4'hF, 32'h1, 0, 0, 0);
    for (int n = 0; n < 260; n++) run_access(32'h2000_0000, 0, 4'hF, 0, 0, 0, 0);
    status_read();

    reset_mid_access();
    status_read();
    run_access(32'h3000_0000, 0, 4'hF, 0, $urandom(), 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
